serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
// - Bit-serial WIDTH-bit adder that drives the decoder-based 1-bit full adder stage.
//   One operand bit pair per clock, LSB first.
// - Accepts a, b and cin on a start pulse and feeds a[i], b[i] and the stored carry
//   into the full adder each cycle. Collects s into a result shift register and
//   recirculates c through a carry flop.
// - Presents sum/cout with a one-cycle done pulse. Sits directly upstream of, and
//   wraps, the 1-bit full adder cell.
// PARAMETERS
// - WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
// - clk     in   1      rising-edge clock
// - rst     in   1      synchronous reset, active-high
// - start   in   1      request; accepted only when busy==0
// - a_in    in   WIDTH  operand A, sampled on accepted start
// - b_in    in   WIDTH  operand B, sampled on accepted start
// - cin_in  in   1      carry-in, sampled on accepted start
// - busy    out  1      high from the cycle after accept through the DONE cycle
// - done    out  1      one-cycle pulse; sum/cout are valid in this cycle
// - sum     out  WIDTH  registered result; held until the next done
// - cout    out  1      registered carry-out; held until the next done
// BEHAVIOUR
// - Reset: clk edge with rst=1 clears all state.
//   - state=IDLE; busy=0, done=0, sum=0, cout=0.
//   - Counter, carry flop and shift registers all = 0.
//   - rst overrides start in the same cycle.
// - FSM states IDLE, RUN, DONE:
//   - IDLE: start=1 -> load A_sr=a_in, B_sr=b_in, carry=cin_in, cnt=0; go to RUN.
//     Otherwise stay in IDLE.
//   - RUN: full adder inputs are (A_sr[0], B_sr[0], carry).
//     - On each edge: S_sr <= {s, S_sr[WIDTH-1:1]}; A_sr/B_sr shift right with 0 fill;
//       carry <= c; cnt <= cnt+1.
//     - When cnt==WIDTH-1 the edge also moves to DONE.
//   - DONE: sum=S_sr, cout=carry and done=1 for exactly one cycle; then back to IDLE.
// - Latency: start accepted at edge t -> done high during cycle t+WIDTH+1
//   (WIDTH RUN cycles + 1 DONE cycle).
// - Throughput: one operation per WIDTH+2 cycles.
// - start while busy (RUN or DONE) is ignored; no queuing; the in-flight op is unaffected.
// - a_in/b_in/cin_in changes after acceptance have no effect.
// - sum/cout update only on entry to DONE; the previous result stays stable during RUN.
// - Arithmetic: {cout,sum} = a_in + b_in + cin_in, modulo 2^(WIDTH+1); no overflow flag.
// - Reset mid-RUN aborts the op: no done pulse; sum/cout forced to 0.
// - cnt width = $clog2(WIDTH); cnt must not wrap before the DONE transition.
// - No combinational path from start or operands to any output; all outputs are registered.
// STRUCTURE
// - Shared header serial_add_defs.vh:
//   - State localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//   - Default WIDTH.
// - One sub-module: the existing decoder-based 1-bit full adder fa_with_d38
//   (a,b,cin -> s,c), instantiated once, combinational.
// - Everything else (FSM, counter, shift registers, carry flop) is in this module.
// TESTING
// - Reset then 8'h00+8'h00 cin=0 -> sum=8'h00 cout=0; done exactly at accept+9 cycles.
// - 8'hFF+8'h01 cin=0 -> sum=8'h00 cout=1; busy high for 9 cycles.
// - 8'hA5+8'h5A cin=1 -> sum=8'h00 cout=1.
//   Then 8'h3C+8'h0F cin=0 -> sum=8'h4B cout=0; old result held until the new done.
// - 8'h12+8'h34 started, start re-pulsed with 8'hFF/8'hFF at RUN cycle 3
//   -> only one done, sum=8'h46 cout=0.
// - rst asserted at RUN cycle 4 of 8'hF0+8'h0F
//   -> busy=0, done=0, sum=0 next cycle.
//   Then 8'h01+8'h01 -> sum=8'h02.
// - WIDTH=3 exhaustive: all 128 (a,b,cin) combinations, back-to-back starts
//   -> {cout,sum} == a+b+cin every op.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding,
// default operand width and counter sizing.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter must hold WIDTH-1 without wrapping; keep at least one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_with_d38.sv
// Decoder-based 1-bit full adder: the 3-to-8 decode of {a,b,cin} selects the
// minterms that make up s and c. Purely combinational.
module fa_with_d38 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  logic [7:0] dec;

  always_comb begin
    dec = '0;
    dec[{a, b, cin}] = 1'b1;
  end

  assign s = dec[1] | dec[2] | dec[4] | dec[7];
  assign c = dec[3] | dec[5] | dec[6] | dec[7];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: feeds one operand bit pair per clock, LSB first,
// through a single full-adder cell and presents {cout,sum} with a done pulse.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Valid/ready contract: start is the request, !busy is the ready; a request
  // is taken only on an edge where both are high, and nothing is queued.
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last_bit;

  assign accept   = (state == ST_IDLE) && start;
  assign last_bit = (state == ST_RUN) && (cnt == LAST);

  fa_with_d38 u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (fa_s),
    .c   (fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sr  <= a_in;
      b_sr  <= b_in;
      carry <= cin_in;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      // Result registers change only on the edge that enters DONE.
      if (last_bit) begin
        sum  <= {fa_s, s_sr[WIDTH-1:1]};
        cout <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and random WIDTH=8 ops
// plus an exhaustive WIDTH=3 sweep, checked through expected-value queues.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start3;
  logic [2:0] a3;
  logic [2:0] b3;
  logic       cin3;
  logic       busy3;
  logic       done3;
  logic [2:0] sum3;
  logic       cout3;

  logic [8:0] exp_q8[$];
  logic [3:0] exp_q3[$];
  logic [8:0] prev_result;
  logic       prev_done8;
  logic       prev_done3;
  int         errors;
  int         checks;
  int         done3_count;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start8),
    .a_in   (a8),
    .b_in   (b8),
    .cin_in (cin8),
    .busy   (busy8),
    .done   (done8),
    .sum    (sum8),
    .cout   (cout8)
  );

  serial_adder_ctrl #(.WIDTH(3)) dut3 (
    .clk    (clk),
    .rst    (rst),
    .start  (start3),
    .a_in   (a3),
    .b_in   (b3),
    .cin_in (cin3),
    .busy   (busy3),
    .done   (done3),
    .sum    (sum3),
    .cout   (cout3)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitors: pop an expectation whenever a done pulse appears.
  initial begin
    prev_done8 = 1'b0;
    prev_done3 = 1'b0;
    done3_count = 0;
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (exp_q8.size() == 0) begin
        check("done8_unexpected", 64'(done8), 64'(0));
      end else begin
        check("result8", 64'({cout8, sum8}), 64'(exp_q8.pop_front()));
      end
      check("done8_single_pulse", 64'(prev_done8), 64'(0));
    end
    prev_done8 = done8;
  end

  always @(negedge clk) begin
    if (!rst && done3) begin
      done3_count++;
      if (exp_q3.size() == 0) begin
        check("done3_unexpected", 64'(done3), 64'(0));
      end else begin
        check("result3", 64'({cout3, sum3}), 64'(exp_q3.pop_front()));
      end
      check("done3_single_pulse", 64'(prev_done3), 64'(0));
    end
    prev_done3 = done3;
  end

  // Driver for the WIDTH=8 instance. Sample k is the negedge inside RUN
  // cycle k; repulse_at/rst_at (0 = off) inject a start or reset at sample k.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input int repulse_at, input int rst_at);
    logic [8:0] exp;
    int         first_done;
    int         busy_cnt;
    bit         aborted;
    exp = 9'(a) + 9'(b) + 9'(cin);
    first_done = 0;
    busy_cnt = 0;
    aborted = 0;
    a8 = a;
    b8 = b;
    cin8 = cin;
    start8 = 1'b1;
    exp_q8.push_back(exp);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    cin8 = 1'($urandom);
    for (int k = 1; k <= 11; k++) begin
      if (rst_at != 0 && k == rst_at + 1) begin
        rst = 1'b0;
        check("abort_busy", 64'(busy8), 64'(0));
        check("abort_done", 64'(done8), 64'(0));
        check("abort_sum", 64'({cout8, sum8}), 64'(0));
        prev_result = '0;
        aborted = 1;
        break;
      end
      if (repulse_at != 0 && k == repulse_at + 1) start8 = 1'b0;
      if (k == repulse_at) begin
        start8 = 1'b1;
        a8 = 8'hFF;
        b8 = 8'hFF;
      end
      if (busy8) busy_cnt++;
      if (done8 && first_done == 0) first_done = k;
      if (busy8 && !done8) check("result_held", 64'({cout8, sum8}), 64'(prev_result));
      if (rst_at != 0 && k == rst_at) begin
        rst = 1'b1;
        void'(exp_q8.pop_back());
      end
      if (k < 11) @(negedge clk);
    end
    start8 = 1'b0;
    if (!aborted) begin
      check("done_latency", 64'(first_done), 64'(9));
      check("busy_cycles", 64'(busy_cnt), 64'(9));
      prev_result = exp;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    prev_result = '0;
    rst = 1'b1;
    start8 = 1'b0;
    a8 = '0;
    b8 = '0;
    cin8 = 1'b0;
    start3 = 1'b0;
    a3 = '0;
    b3 = '0;
    cin3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy8), 64'(0));
    check("reset_done", 64'(done8), 64'(0));
    check("reset_result", 64'({cout8, sum8}), 64'(0));
    check("reset_busy3", 64'(busy3), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    op8(8'h00, 8'h00, 1'b0, 0, 0);
    op8(8'hFF, 8'h01, 1'b0, 0, 0);
    op8(8'hA5, 8'h5A, 1'b1, 0, 0);
    op8(8'h3C, 8'h0F, 1'b0, 0, 0);
    op8(8'h12, 8'h34, 1'b0, 3, 0);
    op8(8'hF0, 8'h0F, 1'b0, 0, 4);
    op8(8'h01, 8'h01, 1'b0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      int rp;
      rp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0;
      op8(8'($urandom), 8'($urandom), 1'($urandom), rp, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Exhaustive WIDTH=3 sweep with starts spaced exactly WIDTH+2 cycles apart.
    for (int cv = 0; cv < 2; cv++) begin
      for (int av = 0; av < 8; av++) begin
        for (int bv = 0; bv < 8; bv++) begin
          a3 = 3'(av);
          b3 = 3'(bv);
          cin3 = 1'(cv);
          start3 = 1'b1;
          exp_q3.push_back(4'(av + bv + cv));
          @(negedge clk);
          start3 = 1'b0;
          a3 = 3'($urandom);
          b3 = 3'($urandom);
          repeat (4) @(negedge clk);
        end
      end
    end

    repeat (6) @(negedge clk);
    check("queue8_drained", 64'(exp_q8.size()), 64'(0));
    check("queue3_drained", 64'(exp_q3.size()), 64'(0));
    check("done3_count", 64'(done3_count), 64'(128));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
